// File: rtl/soc_system_adc_capture_pio.sv
// soc_system_adc_capture_pio: multi-channel synchronised input PIO with sticky change flags, maskable irq and coherent snapshots
module soc_system_adc_capture_pio #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         chipselect,
  input  logic [ADDR_WIDTH-1:0]        address,
  input  logic                         write,
  input  logic [31:0]                  writedata,
  output logic [31:0]                  readdata,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_port,
  output logic                         irq
);
  localparam int W  = NUM_CH * DATA_WIDTH;
  localparam int WW = $clog2(SYNC_STAGES + 2);
  localparam logic [ADDR_WIDTH-1:0] A_CHG = ADDR_WIDTH'(2 * NUM_CH);
  localparam logic [ADDR_WIDTH-1:0] A_MSK = ADDR_WIDTH'(2 * NUM_CH + 1);
  localparam logic [ADDR_WIDTH-1:0] A_CTL = ADDR_WIDTH'(2 * NUM_CH + 2);
  localparam logic [ADDR_WIDTH-1:0] A_SEQ = ADDR_WIDTH'(2 * NUM_CH + 3);
  logic [SYNC_STAGES-1:0][W-1:0] sync;
  logic [W-1:0]      live, prev, snap;
  logic [NUM_CH-1:0] changed, changed_n, irq_mask, diff, clr;
  logic [15:0]       seq;
  logic [WW-1:0]     warm;
  logic [31:0]       rd_n;
  logic              wr, snap_go;
  assign wr      = chipselect & write;
  assign live    = sync[SYNC_STAGES-1];
  assign irq     = |(changed & irq_mask);
  assign clr     = (wr && address == A_CHG) ? writedata[NUM_CH-1:0] : '0;
  assign snap_go = wr && address == A_CTL && writedata[0];
  always_comb begin
    rd_n = '0;
    diff = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      diff[i] = live[i*DATA_WIDTH +: DATA_WIDTH] != prev[i*DATA_WIDTH +: DATA_WIDTH];
      if (address == ADDR_WIDTH'(i)) rd_n = 32'(live[i*DATA_WIDTH +: DATA_WIDTH]);
      if (address == ADDR_WIDTH'(NUM_CH + i)) rd_n = 32'(snap[i*DATA_WIDTH +: DATA_WIDTH]);
    end
    if (address == A_CHG) rd_n = 32'(changed);
    if (address == A_MSK) rd_n = 32'(irq_mask);
    if (address == A_SEQ) rd_n = 32'(seq);
    // set is OR-ed after the clear so a same-cycle change keeps its flag
    changed_n = (changed & ~clr) | (warm == '0 ? diff : '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync     <= '0;
      prev     <= '0;
      snap     <= '0;
      changed  <= '0;
      irq_mask <= '0;
      seq      <= '0;
      readdata <= '0;
      warm     <= WW'(SYNC_STAGES + 1);
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], in_port};
      prev     <= live;
      changed  <= changed_n;
      readdata <= rd_n;
      if (warm != '0) warm <= warm - WW'(1);
      if (wr && address == A_MSK) irq_mask <= writedata[NUM_CH-1:0];
      if (snap_go) begin
        snap <= live;
        seq  <= seq + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_soc_system_adc_capture_pio.sv
// tb_soc_system_adc_capture_pio: directed self-checking bench for the ADC capture PIO
module tb_soc_system_adc_capture_pio;
  logic         clk = 0, reset = 1, chipselect = 0, write = 0;
  logic [3:0]   address = '0;
  logic [31:0]  writedata = '0, readdata, v;
  logic [127:0] in_port = '0;
  logic         irq;
  int           errors = 0, checks = 0;

  soc_system_adc_capture_pio dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .address(address),
    .write(write), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    chipselect = 1; write = 1; address = a; writedata = d;
    tick();
    chipselect = 0; write = 0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    in_port = {16{8'hA5}};
    tick(3);
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    reset = 0;
    tick(6);
    rd(4'd8, v); chk("warmup_changed", v, 32'h0);
    rd(4'd0, v); chk("warmup_live0", v, 32'hA5A5A5A5);

    in_port = '0;
    tick(4);
    wr(4'd8, 32'hF);
    rd(4'd8, v); chk("cleared_changed", v, 32'h0);

    address = 4'd1;
    in_port[32 +: 32] = 32'h1234;
    tick(2); chk("live1_early", readdata, 32'h0);
    tick();  chk("live1_latency", readdata, 32'h1234);
    rd(4'd8, v); chk("changed_ch1", v, 32'h2);
    chk("irq_unmasked", {31'b0, irq}, 32'h0);

    wr(4'd9, 32'hFFFF_FFF2);
    chk("irq_masked_set", {31'b0, irq}, 32'h1);
    rd(4'd9, v); chk("mask_read", v, 32'h2);
    wr(4'd8, 32'h2);
    chk("irq_after_w1c", {31'b0, irq}, 32'h0);
    in_port[32 +: 32] = 32'h5678;
    tick(3);
    chk("irq_reassert", {31'b0, irq}, 32'h1);
    wr(4'd9, 32'h0);
    chk("irq_mask_off", {31'b0, irq}, 32'h0);
    rd(4'd8, v); chk("flag_kept_masked", v, 32'h2);

    wr(4'd8, 32'hF);
    in_port[31:0] = 32'h1;
    tick(2);
    wr(4'd8, 32'h1);
    rd(4'd8, v); chk("race_set_wins", v, 32'h1);
    wr(4'd8, 32'h1);
    rd(4'd8, v); chk("plain_clear", v, 32'h0);

    in_port = {32'd4, 32'd3, 32'd2, 32'd1};
    tick(3);
    wr(4'd10, 32'h1);
    rd(4'd4, v); chk("snap0", v, 32'd1);
    rd(4'd5, v); chk("snap1", v, 32'd2);
    rd(4'd6, v); chk("snap2", v, 32'd3);
    rd(4'd7, v); chk("snap3", v, 32'd4);
    rd(4'd11, v); chk("seq_one", v, 32'd1);
    in_port = {32'd40, 32'd30, 32'd20, 32'd10};
    tick(3);
    rd(4'd4, v); chk("snap0_held", v, 32'd1);
    rd(4'd7, v); chk("snap3_held", v, 32'd4);
    rd(4'd3, v); chk("live3_new", v, 32'd40);
    rd(4'd10, v); chk("ctrl_reads0", v, 32'h0);
    wr(4'd10, 32'h2);
    rd(4'd11, v); chk("ctrl_bit0_clear_noop", v, 32'd1);
    wr(4'd0, 32'hDEAD);
    rd(4'd0, v); chk("live_ro", v, 32'd10);

    chipselect = 1; write = 1; address = 4'd10; writedata = 32'h1;
    tick(65535);
    chipselect = 0; write = 0;
    rd(4'd11, v); chk("seq_wrap", v, 32'h0);
    wr(4'd10, 32'h1);
    rd(4'd11, v); chk("seq_after_wrap", v, 32'h1);
    rd(4'd12, v); chk("unmapped12", v, 32'h0);
    rd(4'd15, v); chk("unmapped15", v, 32'h0);

    wr(4'd9, 32'hF);
    chipselect = 1; write = 1; address = 4'd10; writedata = 32'h1; reset = 1;
    tick();
    chipselect = 0; write = 0; reset = 0;
    chk("reset_mid_rd", readdata, 32'h0);
    rd(4'd11, v); chk("reset_mid_seq", v, 32'h0);
    rd(4'd4, v); chk("reset_mid_snap", v, 32'h0);
    rd(4'd9, v); chk("reset_mid_mask", v, 32'h0);
    chk("reset_mid_irq", {31'b0, irq}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
